conv_14_15_div_seq: RTL and testbench

- Iterative signed divider that undoes the conv_14_15 product scaling.
- Takes a 24-bit signed product/accumulator and an 8-bit signed weight or scale, and returns a 16-bit signed quotient and an 8-bit signed remainder.
- Uses restoring division, one quotient bit per cycle, and shares the ap_start/ap_done/ap_idle/ap_ready handshake of the conv_14_15 HLS datapath.
- Sits downstream of the conv_14_15 multiplier in the requantization and normalization path.

---
 rtl/conv_14_15_div_seq.sv | 192 +++++++++++++++++++
 tb/tb_conv_14_15_div_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_14_15_div_seq.sv
// Iterative signed divider for the conv_14_15 requantization path: one restoring
// step per cycle, C-style signed results, quotient saturated to dout_WIDTH bits.
module conv_14_15_div_seq #(
  parameter int unsigned ID         = 32'd1,
  parameter int unsigned din0_WIDTH = 32'd24,
  parameter int unsigned din1_WIDTH = 32'd8,
  parameter int unsigned dout_WIDTH = 32'd16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  ap_idle,
  output logic                  ap_ready,
  output logic                  ap_done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  dbz,
  output logic [1:0]            o_dbg_state
);

  // Handshake: a request is taken when ap_start=1 at a rising edge while
  // ap_idle=1; ap_start at any other time is ignored. ap_done/ap_ready pulse
  // together for one cycle, and dout/rem/ovf/dbz are valid from that cycle on.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int unsigned CW = $clog2(din0_WIDTH);
  localparam logic [CW-1:0]         C_LAST    = CW'(din0_WIDTH - 1);
  localparam logic [CW-1:0]         C_CNT_ONE = CW'(1);
  localparam logic [din0_WIDTH-1:0] C_ONE0    = din0_WIDTH'(1);
  localparam logic [din1_WIDTH-1:0] C_ONE1    = din1_WIDTH'(1);
  localparam logic [dout_WIDTH-1:0] C_ONEQ    = dout_WIDTH'(1);
  localparam logic [din0_WIDTH-1:0] C_QPOS    = din0_WIDTH'((64'd1 << (dout_WIDTH - 1)) - 64'd1);
  localparam logic [din0_WIDTH-1:0] C_QNEG    = din0_WIDTH'(64'd1 << (dout_WIDTH - 1));
  localparam logic [dout_WIDTH-1:0] C_SAT_POS = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] C_SAT_NEG = {1'b1, {(dout_WIDTH-1){1'b0}}};

  state_t r_state;
  state_t w_next;

  logic [din0_WIDTH-1:0] r_dvd;
  logic [din1_WIDTH-1:0] r_dvs;
  logic [din1_WIDTH-1:0] r_prem;
  logic [CW-1:0]         r_cnt;
  logic                  r_sign_q;
  logic                  r_sign_r;
  logic                  r_zero;
  logic [dout_WIDTH-1:0] r_dout;
  logic [din1_WIDTH-1:0] r_rem;
  logic                  r_ovf;
  logic                  r_dbz;

  logic [din0_WIDTH-1:0] w_mag0;
  logic [din1_WIDTH-1:0] w_mag1;
  logic [din1_WIDTH:0]   w_shift;
  logic [din1_WIDTH+1:0] w_diff;
  logic                  w_qbit;
  logic [din1_WIDTH:0]   w_sel;
  logic                  w_last;
  logic                  w_ovf_pos;
  logic                  w_ovf_neg;
  logic [dout_WIDTH-1:0] w_q_low;
  logic [dout_WIDTH-1:0] w_q_signed;
  logic [din1_WIDTH-1:0] w_rem_signed;
  logic                  w_unused_bits;

  // Two's-complement magnitudes; the most negative inputs map to 2^(W-1) unsigned.
  assign w_mag0 = din0[din0_WIDTH-1] ? (~din0 + C_ONE0) : din0;
  assign w_mag1 = din1[din1_WIDTH-1] ? (~din1 + C_ONE1) : din1;

  // Partial remainder stays below the divisor magnitude, so one extra bit
  // holds the shifted value and a second extra bit catches the borrow.
  assign w_shift = {r_prem, r_dvd[din0_WIDTH-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_dvs};
  assign w_qbit  = ~w_diff[din1_WIDTH+1];
  assign w_sel   = w_qbit ? w_diff[din1_WIDTH:0] : w_shift;
  assign w_last  = (r_cnt == C_LAST);

  assign w_unused_bits = ^{ID, w_sel[din1_WIDTH]};

  // After the last step r_dvd holds the unsigned quotient magnitude.
  assign w_ovf_pos    = !r_sign_q && (r_dvd > C_QPOS);
  assign w_ovf_neg    = r_sign_q && (r_dvd > C_QNEG);
  assign w_q_low      = r_dvd[dout_WIDTH-1:0];
  assign w_q_signed   = r_sign_q ? (~w_q_low + C_ONEQ) : w_q_low;
  assign w_rem_signed = r_sign_r ? (~r_prem + C_ONE1) : r_prem;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (ap_start) w_next = S_CALC;
      S_CALC: if (w_last) w_next = S_FIN;
      S_FIN:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ap_idle  = 1'b0;
    ap_done  = 1'b0;
    ap_ready = 1'b0;
    case (r_state)
      S_IDLE: ap_idle = 1'b1;
      S_DONE: begin
        ap_done  = 1'b1;
        ap_ready = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_prem   <= '0;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_zero   <= 1'b0;
      r_dout   <= '0;
      r_rem    <= '0;
      r_ovf    <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ap_start) begin
            r_dvd    <= w_mag0;
            r_dvs    <= w_mag1;
            r_prem   <= '0;
            r_cnt    <= '0;
            r_sign_q <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
            r_sign_r <= din0[din0_WIDTH-1];
            r_zero   <= (din1 == '0);
          end
        end
        S_CALC: begin
          r_dvd  <= {r_dvd[din0_WIDTH-2:0], w_qbit};
          r_prem <= w_sel[din1_WIDTH-1:0];
          r_cnt  <= r_cnt + C_CNT_ONE;
        end
        S_FIN: begin
          if (r_zero) begin
            r_dout <= r_sign_r ? C_SAT_NEG : C_SAT_POS;
            r_rem  <= '0;
            r_ovf  <= 1'b0;
            r_dbz  <= 1'b1;
          end else begin
            r_rem <= w_rem_signed;
            r_dbz <= 1'b0;
            if (w_ovf_pos) begin
              r_dout <= C_SAT_POS;
              r_ovf  <= 1'b1;
            end else if (w_ovf_neg) begin
              r_dout <= C_SAT_NEG;
              r_ovf  <= 1'b1;
            end else begin
              r_dout <= w_q_signed;
              r_ovf  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dout        = r_dout;
  assign rem         = r_rem;
  assign ovf         = r_ovf;
  assign dbz         = r_dbz;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_conv_14_15_div_seq.sv
// Bench for conv_14_15_div_seq: directed literal vectors, handshake/reset
// scenarios and random operands, all checked against a C-semantics model.
module tb_conv_14_15_div_seq;

  localparam int W0 = 24;
  localparam int W1 = 8;
  localparam int WQ = 16;
  localparam int LAT = 25;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic          ap_start = 1'b0;
  logic [W0-1:0] din0 = '0;
  logic [W1-1:0] din1 = '0;
  logic          ap_idle, ap_ready, ap_done, ovf, dbz;
  logic [WQ-1:0] dout;
  logic [W1-1:0] rem;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // {done cycle[31:0], dout[15:0], rem[7:0], ovf, dbz}
  logic [57:0] exp_q[$];

  conv_14_15_div_seq #(
    .ID(32'd1), .din0_WIDTH(32'd24), .din1_WIDTH(32'd8), .dout_WIDTH(32'd16)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .din0(din0), .din1(din1),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done),
    .dout(dout), .rem(rem), .ovf(ovf), .dbz(dbz),
    .o_dbg_state(dbg_state)
  );

  // clock / cycle count
  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // C semantics: truncating quotient, remainder follows dividend, then saturate.
  function automatic logic [25:0] model(input int a, input int b);
    int q, r;
    logic [15:0] d;
    logic [7:0]  rm;
    logic        o, z;
    if (b == 0) begin
      d  = (a < 0) ? 16'h8000 : 16'h7FFF;
      rm = '0;
      o  = 1'b0;
      z  = 1'b1;
    end else begin
      q  = a / b;
      r  = a % b;
      rm = r[7:0];
      z  = 1'b0;
      o  = 1'b1;
      if (q > 32767) d = 16'h7FFF;
      else if (q < -32768) d = 16'h8000;
      else begin
        d = q[15:0];
        o = 1'b0;
      end
    end
    return {d, rm, o, z};
  endfunction

  // scoreboard: every cycle out of reset
  always @(negedge ap_clk) begin
    logic [57:0] e;
    if (!ap_rst) begin
      chk("ready_vs_done", int'(ap_ready), int'(ap_done));
      if (ap_done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("latency_cycle", cyc, int'(e[57:26]));
          chk("dout", int'($signed(dout)), int'($signed(e[25:10])));
          chk("rem", int'($signed(rem)), int'($signed(e[9:2])));
          chk("ovf", int'(ovf), int'(e[1]));
          chk("dbz", int'(dbz), int'(e[0]));
        end
      end else if (exp_q.size() != 0 && cyc > int'(exp_q[0][57:26])) begin
        chk("missing_done", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge ap_clk);
    while (!ap_idle && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    if (!ap_idle) chk("idle_timeout", int'(ap_idle), 1);
  endtask

  // drives one request, records the accepting edge, scrambles inputs afterwards
  task automatic start_op(input int a, input int b, output int k);
    wait_idle();
    din0 = W0'(a);
    din1 = W1'(b);
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    k = cyc;
    exp_q.push_back({32'(k + LAT), model(a, b)});
    ap_start = 1'b0;
    din0 = W0'($urandom);
    din1 = W1'($urandom);
  endtask

  task automatic check_lit(input int a, input int b, input int e_q, input int e_r,
                           input int e_o, input int e_z);
    int k, n;
    start_op(a, b, k);
    n = 0;
    do begin
      @(negedge ap_clk);
      n++;
    end while (!ap_done && n < 40);
    if (!ap_done) chk("lit_done_timeout", 0, 1);
    else begin
      chk("lit_latency", cyc - k, LAT);
      chk("lit_dout", int'($signed(dout)), e_q);
      chk("lit_rem", int'($signed(rem)), e_r);
      chk("lit_ovf", int'(ovf), e_o);
      chk("lit_dbz", int'(dbz), e_z);
    end
  endtask

  typedef struct { int a; int b; int q; int r; int o; int z; } vec_t;
  vec_t vecs[19] = '{
    '{1000, 7, 142, 6, 0, 0},
    '{-1000, 7, -142, -6, 0, 0},
    '{1000, -7, -142, 6, 0, 0},
    '{-1000, -7, 142, -6, 0, 0},
    '{100000, 1, 32767, 0, 1, 0},
    '{-8388608, -1, 32767, 0, 1, 0},
    '{-8388608, 127, -32768, -4, 1, 0},
    '{-8388608, -128, 32767, 0, 1, 0},
    '{5, 0, 32767, 0, 0, 1},
    '{-5, 0, -32768, 0, 0, 1},
    '{0, 0, 32767, 0, 0, 1},
    '{32767, 1, 32767, 0, 0, 0},
    '{-32768, 1, -32768, 0, 0, 0},
    '{32768, 1, 32767, 0, 1, 0},
    '{-32769, 1, -32768, 0, 1, 0},
    '{8388607, -128, -32768, 127, 1, 0},
    '{0, -3, 0, 0, 0, 0},
    '{-7, 100, 0, -7, 0, 0},
    '{127, -128, 0, 127, 0, 0}
  };

  task automatic check_reset_state(input string tag);
    chk({tag, "_idle"}, int'(ap_idle), 1);
    chk({tag, "_done"}, int'(ap_done), 0);
    chk({tag, "_ready"}, int'(ap_ready), 0);
    chk({tag, "_dout"}, int'(dout), 0);
    chk({tag, "_rem"}, int'(rem), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_dbz"}, int'(dbz), 0);
  endtask

  initial begin
    int k, prev, n, a, b, sel;
    logic signed [W0-1:0] ra;
    logic signed [W1-1:0] rb;

    // reset
    ap_rst = 1'b1;
    repeat (3) @(negedge ap_clk);
    check_reset_state("reset");
    ap_rst = 1'b0;

    // directed literal vectors
    for (int i = 0; i < 19; i++)
      check_lit(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].o, vecs[i].z);

    // reset mid-calculation aborts without a done pulse
    start_op(1000, 7, k);
    repeat (10) @(negedge ap_clk);
    ap_rst = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge ap_clk);
    ap_rst = 1'b0;
    check_reset_state("abort");
    repeat (30) @(negedge ap_clk);

    // ap_start held high: one acceptance every 27 edges
    wait_idle();
    din0 = W0'(-1000);
    din1 = W1'(7);
    ap_start = 1'b1;
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) wait_idle();
      @(posedge ap_clk);
      #1;
      k = cyc;
      exp_q.push_back({32'(k + LAT), model(-1000, 7)});
      if (i > 0) chk("held_start_period", k - prev, 27);
      prev = k;
    end
    ap_start = 1'b0;

    // start pulses while busy are ignored
    start_op(-30000, 3, k);
    for (int j = 0; j <= 26; j++) begin
      @(negedge ap_clk);
      ap_start = (j == 3 || j == 10 || j == 24 || j == 25);
    end
    ap_start = 1'b0;

    // random operands, biased toward edge cases
    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom_range(0, 3));
      ra = W0'($urandom);
      rb = W1'($urandom);
      a = int'(ra);
      b = int'(rb);
      case (sel)
        1: a = int'($urandom_range(0, 4000)) - 2000;
        2: begin
          a = ($urandom_range(0, 1) == 0) ? -8388608 : 8388607;
          b = int'($urandom_range(0, 4)) - 2;
        end
        3: if ($urandom_range(0, 3) == 0) b = 0;
        default: ;
      endcase
      start_op(a, b, k);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge ap_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
